// File: rtl/lsm_readout_classifier.sv
// Readout classifier for the LSM reservoir.
// It counts the spikes on the two output-neuron lines over a fixed window and
// registers a class decision together with a one-cycle valid pulse. During
// training windows it also drives the reservoir teacher controls from the
// label that was latched when the window started.
module lsm_readout_classifier #(
    parameter int unsigned WINDOW_LEN = 950000,
    parameter int unsigned TMR_W      = 20,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             train,
    input  logic             label,
    input  logic             spike_out1,
    input  logic             spike_out2,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic             decision,
    output logic             tie,
    output logic             hit,
    output logic             decision_valid,
    output logic             busy,
    output logic             ST1,
    output logic             ST2,
    output logic             CT1,
    output logic             CT2
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_DECIDE = 2'd2
    } state_t;

    // Timer value at which the final sample of a window is taken.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Saturating increment: the accumulator sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_W'(1'b1);
        end else begin
            return v;
        end
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              start_s;
    logic              sample_s;
    logic              decide_s;
    logic              train_next_s;
    logic              label_next_s;
    logic              teach_on_s;

    logic [TMR_W-1:0]  timer_r;
    logic [CNT_W-1:0]  acc1_r;
    logic [CNT_W-1:0]  acc2_r;
    logic              train_l_r;
    logic              label_l_r;
    logic [CNT_W-1:0]  count1_r;
    logic [CNT_W-1:0]  count2_r;
    logic              decision_r;
    logic              tie_r;
    logic              hit_r;
    logic              valid_r;
    logic              busy_r;
    logic              st1_r;
    logic              st2_r;
    logic              ct1_r;
    logic              ct2_r;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a started window always runs to completion.
    always_comb begin
        state_next_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    state_next_s = S_COUNT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_COUNT: begin
                if (timer_r == TMR_LAST) begin
                    state_next_s = S_DECIDE;
                end else begin
                    state_next_s = S_COUNT;
                end
            end
            S_DECIDE: begin
                if (enable) begin
                    state_next_s = S_COUNT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        start_s  = 1'b0;
        sample_s = 1'b0;
        decide_s = 1'b0;
        case (state_r)
            S_IDLE:   start_s = enable;
            S_COUNT:  sample_s = 1'b1;
            S_DECIDE: begin
                decide_s = 1'b1;
                start_s  = enable;
            end
            default: begin
                start_s  = 1'b0;
                sample_s = 1'b0;
                decide_s = 1'b0;
            end
        endcase
    end

    // Train/label values that will be in force next cycle, used to register
    // the teacher outputs so they line up with the COUNT state.
    always_comb begin
        if (start_s) begin
            train_next_s = train;
            label_next_s = label;
        end else begin
            train_next_s = train_l_r;
            label_next_s = label_l_r;
        end
        teach_on_s = (state_next_s == S_COUNT) && train_next_s;
    end

    // Window timer, spike accumulators and latched window attributes.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer_r   <= '0;
            acc1_r    <= '0;
            acc2_r    <= '0;
            train_l_r <= 1'b0;
            label_l_r <= 1'b0;
        end else if (start_s) begin
            timer_r   <= '0;
            acc1_r    <= '0;
            acc2_r    <= '0;
            train_l_r <= train;
            label_l_r <= label;
        end else if (sample_s) begin
            timer_r   <= timer_r + TMR_W'(1'b1);
            acc1_r    <= sat_inc(acc1_r, spike_out1);
            acc2_r    <= sat_inc(acc2_r, spike_out2);
        end else begin
            timer_r   <= timer_r;
            acc1_r    <= acc1_r;
            acc2_r    <= acc2_r;
        end
    end

    // Result registers, updated only when leaving DECIDE.
    always_ff @(posedge clock) begin
        if (reset) begin
            count1_r   <= '0;
            count2_r   <= '0;
            decision_r <= 1'b0;
            tie_r      <= 1'b0;
            hit_r      <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= decide_s;
            if (decide_s) begin
                count1_r   <= acc1_r;
                count2_r   <= acc2_r;
                decision_r <= (acc2_r > acc1_r);
                tie_r      <= (acc1_r == acc2_r);
                hit_r      <= train_l_r && (acc1_r != acc2_r) && ((acc2_r > acc1_r) == label_l_r);
            end else begin
                count1_r   <= count1_r;
                count2_r   <= count2_r;
                decision_r <= decision_r;
                tie_r      <= tie_r;
                hit_r      <= hit_r;
            end
        end
    end

    // Busy flag and teacher controls, registered from the upcoming state.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= 1'b0;
            st1_r  <= 1'b0;
            st2_r  <= 1'b0;
            ct1_r  <= 1'b0;
            ct2_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s != S_IDLE);
            st1_r  <= teach_on_s && !label_next_s;
            st2_r  <= teach_on_s && label_next_s;
            ct1_r  <= teach_on_s;
            ct2_r  <= teach_on_s;
        end
    end

    assign count1         = count1_r;
    assign count2         = count2_r;
    assign decision       = decision_r;
    assign tie            = tie_r;
    assign hit            = hit_r;
    assign decision_valid = valid_r;
    assign busy           = busy_r;
    assign ST1            = st1_r;
    assign ST2            = st2_r;
    assign CT1            = ct1_r;
    assign CT2            = ct2_r;

endmodule

// File: doc/lsm_readout_classifier.md
Name: lsm_readout_classifier

Overview:
- Downstream readout stage for LSM_reservoir. Consumes its two output-neuron spike lines (output_reg1/output_reg2).
- Counts spikes from each output neuron over a fixed time window and issues a registered class decision with a one-cycle valid pulse.
- During training windows, drives the reservoir's per-neuron teacher controls (ST1/ST2/CT1/CT2) from the window's latched label.

Parameters:
- WINDOW_LEN, 950000, window length in clock cycles (spike samples per window); legal range 1..2^TMR_W.
- TMR_W, 20, width of the window timer.
- CNT_W, 16, width of the spike accumulators and result counts.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start a window; holding it high runs back-to-back windows.
- train  in  1  1 = training window (teacher outputs active); latched at window start.
- label  in  1  target class (0 = neuron 1, 1 = neuron 2); latched at window start.
- spike_out1  in  1  reservoir output_reg1.
- spike_out2  in  1  reservoir output_reg2.
- count1  out  CNT_W  latched spike count of neuron 1 for the last window.
- count2  out  CNT_W  latched spike count of neuron 2 for the last window.
- decision  out  1  winning class.
- tie  out  1  counts were equal in the last window.
- hit  out  1  training window only: decision matched label and tie=0.
- decision_valid  out  1  one-cycle pulse when the result registers update.
- busy  out  1  state is not IDLE.
- ST1, ST2, CT1, CT2  out  1 each  teacher and learning controls to the reservoir.

Behaviour:
- Reset: state=IDLE. Timer, accumulators, count1, count2, decision, tie, hit, decision_valid, busy and ST/CT are all 0. Reset overrides everything, including mid-window; a partial window is discarded and produces no valid pulse.
- FSM states: IDLE, COUNT, DECIDE.
- IDLE:
  - If enable=1 at an edge: go to COUNT.
  - On that edge: clear the accumulators, set timer=0, latch train and label.
- COUNT:
  - At each edge, add spike_out1 and spike_out2 into their accumulators.
  - Timer increments at each edge.
  - At the edge where timer==WINDOW_LEN-1, the final sample is taken and the state goes to DECIDE.
  - Exactly WINDOW_LEN samples are taken per window.
  - enable is ignored while in COUNT; a window always completes.
- Accumulators saturate at 2^CNT_W-1 and never wrap. Both inputs high in the same cycle increment both accumulators.
- DECIDE (one cycle). On its exit edge, the block registers:
  - count1 and count2.
  - decision = 1 if count2>count1, else 0.
  - tie = (count1==count2).
  - hit = train_l & ~tie & (decision==label_l); hit is 0 for inference windows.
  - decision_valid = 1 for exactly the following cycle.
- DECIDE exit transition:
  - enable=1: go to COUNT with a fresh clear and latch of train/label, so consecutive windows start WINDOW_LEN+1 cycles apart.
  - enable=0: go to IDLE.
- Result registers hold their values until the next DECIDE.
- Timing: if enable is sampled at edge t0, samples are taken at edges t1..tW (W=WINDOW_LEN) and results register at edge tW+1. decision_valid is high from tW+1 to tW+2.
- Teacher outputs are registered and reflect the current state:
  - While in COUNT with train_l=1: ST1=~label_l, ST2=label_l, CT1=CT2=1.
  - Otherwise: all four are 0.
- busy = (state != IDLE).

Test Plan:
1. WINDOW_LEN=8, CNT_W=4: reset, pulse enable, spike_out1=1 every cycle, spike_out2=0 -> count1=8, count2=0, decision=0, tie=0, and a single decision_valid pulse 9 cycles after the enable edge.
2. WINDOW_LEN=8: 3 spikes on each input, two of them simultaneous -> count1=3, count2=3, tie=1, decision=0, hit=0.
3. WINDOW_LEN=20, CNT_W=4, spike_out2=1 constantly -> count2=15 (saturated, no wrap), decision=1.
4. train=1, label=1, WINDOW_LEN=8, spike_out2 in 5 cycles and spike_out1 in 2 cycles -> ST2=1, ST1=0, CT1=CT2=1 for exactly 8 cycles, all 0 in DECIDE/IDLE, then decision=1 and hit=1. Changing train/label mid-window has no effect.
5. enable held high across 3 windows of WINDOW_LEN=8 -> decision_valid pulses spaced 9 cycles apart and busy stays 1. Drop enable and, after the current window, the FSM returns to IDLE and busy=0.
6. Assert reset at sample 5 of a window -> all outputs 0 the next cycle, state IDLE, no decision_valid. A new enable then gives a full 8-sample count.
